hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Load-use hazard and branch-flush controller for the 5-stage pipeline. Compares ID-stage source regs against the
//  load held in the ID/EX register and drives the stall input of id_ex (bubble), plus PC/IF-ID hold and IF/ID flush.
//  A small FSM stretches a stall over LOAD_LAT cycles and sequences multi-cycle flushes. A saturating counter totals stall cycles.
// PARAMETERS
//  LOAD_LAT  1   stall cycles per load-use hazard (>=1; 1 = single bubble with MEM->EX forwarding)
//  FLUSH_CYC 1   cycles ifid_flush stays high after a taken branch (>=1)
//  CNT_W     32  width of stall_count
// PORTS
//  clk           in   1      pipeline clock; all state updates on negedge clk, same edge as the pipeline registers
//  rst           in   1      synchronous, active-high reset
//  rs_2          in   5      ID-stage rs field
//  rt_2          in   5      ID-stage rt field
//  use_rs_2      in   1      ID instruction reads rs
//  use_rt_2      in   1      ID instruction reads rt
//  MemRead_3     in   1      EX-stage instruction is a load
//  RegWr_3       in   1      EX-stage instruction writes a register
//  dst_3         in   5      EX-stage destination register (post RegDst mux)
//  branch_taken  in   1      taken branch/jump resolved this cycle (1-cycle pulse)
//  stall         out  1      to id_ex stall: insert a bubble (clear control)
//  pc_hold       out  1      freeze PC
//  ifid_hold     out  1      freeze IF/ID register
//  ifid_flush    out  1      clear IF/ID register to NOP
//  stall_count   out  CNT_W  total cycles with stall=1, saturating
// BEHAVIOUR
//  hazard = MemRead_3 & RegWr_3 & (dst_3!=0) & ((use_rs_2 & rs_2==dst_3) | (use_rt_2 & rt_2==dst_3)).
//  States: IDLE, STALL, FLUSH. Registers: state, cnt (width ceil(log2(max(LOAD_LAT,FLUSH_CYC)))+1), stall_count.
//  Reset (rst=1 at an edge): state=IDLE, cnt=0, stall_count=0. All outputs are 0 in IDLE with no hazard and no branch.
//   rst has priority over every other input. If rst is asserted mid-stall or mid-flush, the next cycle is IDLE with outputs 0.
//  IDLE:
//   - branch_taken=1: ifid_flush=1 this cycle, stall=pc_hold=ifid_hold=0 (flush beats hazard).
//     If FLUSH_CYC>1, go to FLUSH with cnt=FLUSH_CYC-1.
//   - else hazard=1: stall=pc_hold=ifid_hold=1 this cycle (combinational, Mealy).
//     If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1.
//   - else: stay in IDLE.
//  STALL: stall=pc_hold=ifid_hold=1 regardless of hazard. The bubble has already moved the load out of EX, so no recompare.
//   - cnt decrements each edge. Return to IDLE on the edge where cnt==1.
//   - Total stall cycles per hazard = LOAD_LAT exactly.
//   - branch_taken=1 in STALL: abort the stall this cycle (stall/pc_hold/ifid_hold=0, ifid_flush=1).
//     Go to FLUSH (cnt=FLUSH_CYC-1), or to IDLE if FLUSH_CYC==1.
//  FLUSH: ifid_flush=1, all other outputs 0. Hazard is ignored.
//   - cnt decrements; go to IDLE on the edge where cnt==1.
//   - A new branch_taken in FLUSH reloads cnt=FLUSH_CYC-1.
//  After the final stall cycle (the IDLE cycle that follows), hazard is re-evaluated normally. Back-to-back load-use pairs each stall.
//  stall_count increments by 1 on every edge where stall=1 and rst=0. It holds at all-ones (2^CNT_W-1), no wrap.
//  dst_3==0 never causes a stall (writes to $0 are discarded).
//  Invariant: ifid_hold and ifid_flush are never both 1. pc_hold==ifid_hold==stall at all times.
// TESTING
//  1 Defaults; lw $1 in EX, ID "add $2,$1,$3" (use_rs, rs_2=1) -> stall=1 for exactly 1 cycle, stall_count=1.
//  2 LOAD_LAT=3, same hazard -> stall high 3 consecutive cycles, with MemRead_3 dropped to 0 after cycle 1; then IDLE, stall_count=3.
//  3 Hazard and branch_taken in the same cycle -> ifid_flush=1, stall=0, stall_count unchanged.
//    LOAD_LAT=3 with branch in stall cycle 2 -> stall ends, flush=1.
//  4 dst_3=0 with rs_2=0, and rt_2 match with use_rt_2=0 -> no stall. lw dst_3=5 with RegWr_3=0 -> no stall.
//  5 FLUSH_CYC=2, branch pulse -> ifid_flush high 2 cycles. rst asserted in cycle 2 -> next cycle all outputs 0, stall_count=0.
//  6 CNT_W=4, 20 hazards -> stall_count saturates at 15. Random check: ifid_hold&ifid_flush never 1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall and branch-flush controller for the 5-stage pipeline
module hazard_ctrl #(
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_2,
  input  logic [4:0]       rt_2,
  input  logic             use_rs_2,
  input  logic             use_rt_2,
  input  logic             MemRead_3,
  input  logic             RegWr_3,
  input  logic [4:0]       dst_3,
  input  logic             branch_taken,
  output logic             stall,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MAXC = (LOAD_LAT > FLUSH_CYC) ? LOAD_LAT : FLUSH_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q;
  logic             hazard;
  logic             stall_d;

  assign hazard = MemRead_3 & RegWr_3 & (dst_3 != 5'd0) &
                  ((use_rs_2 & (rs_2 == dst_3)) | (use_rt_2 & (rt_2 == dst_3)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_d    = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      IDLE: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_CYC - 1);
          end
        end else if (hazard) begin
          stall_d = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = CW'(LOAD_LAT - 1);
          end
        end
      end
      STALL: begin
        // a taken branch kills the stalled instruction, so the stall is abandoned
        if (branch_taken) begin
          ifid_flush = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_CYC - 1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          stall_d = 1'b1;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        if (branch_taken) begin
          if (FLUSH_CYC > 1) begin
            cnt_d = CW'(FLUSH_CYC - 1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state moves on the falling edge together with the pipeline registers
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_d && (stall_count_q != {CNT_W{1'b1}}))
        stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign stall       = stall_d;
  assign pc_hold     = stall_d;
  assign ifid_hold   = stall_d;
  assign stall_count = stall_count_q;

endmodule
